pwm_multi: RTL and testbench
============================

PWM_MULTI -- requirements
Module: pwm_multi

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of independent PWM channels (1..16).
REQ-002 SHALL have parameter WIDTH, default 8, meaning counter/duty/period bit width.
REQ-003 SHALL have parameter INVERT, default 0 (NUM_CH bits), meaning per-channel output polarity mask.
REQ-004 SHALL have parameter FADE_STEP, default 1, meaning duty increment per period when fading is compiled in.
REQ-005 SHALL have one clock and an asynchronous, active-low reset.
REQ-006 SHALL have the following ports, one per line:
- clk  input  1  system clock
- reset_n  input  1  asynchronous active-low reset
- en  input  1  global run enable
- period  input  WIDTH  terminal count; PWM period is period+1 cycles
- wr_valid  input  1  duty-write request
- wr_ready  output  1  duty-write accept
- wr_ch  input  CHW=$clog2(NUM_CH) or 1  target channel
- wr_duty  input  WIDTH  new duty value
- pwm_out  output  NUM_CH  PWM outputs
- period_tick  output  1  one-cycle pulse on period wrap
- err_ch  output  1  sticky flag for out-of-range wr_ch

Function
REQ-007 SHALL run a free counter 0..period_q, wrapping to 0 on the cycle after it equals period_q.
REQ-008 SHALL sample period into period_q only on wrap; mid-period changes take effect at the next period.
REQ-009 SHALL assert period_tick for exactly the cycle in which counter equals period_q and en is high.
REQ-010 SHALL drive pwm_out[i] = (counter < active_duty[i]) XOR INVERT[i], registered, 1-cycle latency from counter.
REQ-011 SHALL treat duty 0 as constant inactive and duty > period_q as constant active, with no glitch.
REQ-012 SHALL, for period_q == 0, assert period_tick every enabled cycle and drive a channel active iff its duty is nonzero.
REQ-013 SHALL transfer a write when wr_valid and wr_ready are both high, storing wr_duty into shadow_duty[wr_ch].
REQ-014 SHALL keep wr_ready high except in the period_tick cycle (commit cycle) and while in reset.
REQ-015 SHALL, on period_tick, commit every shadow_duty into active_duty, so updates are period-aligned and glitch-free.
REQ-016 SHALL accept but discard a write with wr_ch >= NUM_CH, and set err_ch, which stays set until reset.
REQ-017 SHALL, while en is low, hold counter at 0, drive outputs at inactive level (INVERT[i]), suppress period_tick, load period_q from period, and copy shadow into active every cycle.
REQ-018 SHALL, on en rising, begin counting from 0 with the current shadow values already active.
REQ-019 SHALL apply the latest accepted write per channel when several writes to one channel occur within a period.

Reset
REQ-020 SHALL, while reset_n is low, asynchronously clear counter, shadow_duty, active_duty, period_tick, wr_ready and err_ch.
REQ-021 SHALL, while reset_n is low, set period_q to all ones and pwm_out to INVERT.
REQ-022 SHALL raise wr_ready on the first clk edge after reset_n deasserts.
REQ-023 SHALL abort any in-progress fade or period on reset, with no partial commit.

Configuration
REQ-024 SHALL, with macro PWM_FADE_EN defined, move each active_duty toward shadow_duty by FADE_STEP per period_tick, saturating at the target without overshoot. While en is low, active_duty SHALL still copy directly from shadow_duty.
REQ-025 SHALL, without PWM_FADE_EN, commit shadow to active in one step on period_tick (REQ-015).

Structure
REQ-026 SHALL place default parameter constants, the CHW width function and a channel-state typedef in package pwm_pkg.
REQ-027 SHALL instantiate sub-module pwm_channel once per channel, containing shadow/active registers, fade logic and compare/polarity output.

Verification
REQ-028 SHALL cover basic duty: WIDTH=8, period=9, ch0 duty=3, en=1 -> pwm_out[0] high 3 of every 10 cycles, period_tick every 10th cycle.
REQ-029 SHALL cover period-aligned update: write ch1 duty=7 mid-period -> pwm_out[1] is unchanged until the cycle after the next period_tick, then high 7 cycles; wr_ready is low in the tick cycle.
REQ-030 SHALL cover boundaries: duty=0 -> constant 0; duty=10 with period=9 -> constant 1; period=0 with duty=1 -> constant 1 and period_tick every cycle; INVERT=4'b0001 -> ch0 complemented.
REQ-031 SHALL cover bad channel: NUM_CH=4, wr_ch=5 written (NUM_CH=4 gives CHW=2, so the bench sets NUM_CH=6 with only 4 channels instantiated, or NUM_CH=3 with wr_ch=3) -> err_ch set and sticky, no channel changes.
REQ-032 SHALL cover fade: PWM_FADE_EN, FADE_STEP=2, active=0, shadow=5 -> active_duty 2, 4, 5 on successive ticks.
REQ-033 SHALL cover reset mid-period: reset_n low at counter=4 -> outputs immediately equal INVERT, all duties 0; after release, wr_ready is high one cycle later.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared defaults, channel-index width helper and channel mode type for the
// multi-channel PWM block.
package pwm_pkg;

    localparam int DEF_NUM_CH    = 4;
    localparam int DEF_WIDTH     = 8;
    localparam int DEF_FADE_STEP = 1;

    // Width of the channel-select field; never narrower than one bit.
    function automatic int chw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Per-channel output mode derived from the active duty and period.
    typedef enum logic [1:0] {
        CH_OFF,
        CH_PWM,
        CH_ON
    } ch_mode_t;

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active duty registers, saturating fade toward the
// shadow value, and the registered compare/polarity output stage.
module pwm_channel
    import pwm_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter logic             INV   = 1'b0,
    parameter logic [WIDTH-1:0] STEP  = '1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             commit,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic [WIDTH-1:0] counter,
    input  logic [WIDTH-1:0] period_q,
    output logic             pwm_out
);

    logic [WIDTH-1:0] shadow_duty;
    logic [WIDTH-1:0] active_duty;
    logic [WIDTH-1:0] fade_next;
    ch_mode_t         mode;

    // Next active duty: move toward shadow by STEP, landing exactly on it.
    always_comb begin
        fade_next = active_duty;
        if (shadow_duty > active_duty) begin
            if ((shadow_duty - active_duty) > STEP)
                fade_next = active_duty + STEP;
            else
                fade_next = shadow_duty;
        end else if (active_duty > shadow_duty) begin
            if ((active_duty - shadow_duty) > STEP)
                fade_next = active_duty - STEP;
            else
                fade_next = shadow_duty;
        end
    end

    // Classify duty so 0 and over-period values give flat, glitch-free levels.
    always_comb begin
        mode = CH_PWM;
        if (active_duty == '0)
            mode = CH_OFF;
        else if (active_duty > period_q)
            mode = CH_ON;
    end

    // Shadow register takes every accepted write for this channel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            shadow_duty <= '0;
        else if (wr_en)
            shadow_duty <= wr_duty;
    end

    // Active register: direct copy while disabled, fade step on each commit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            active_duty <= '0;
        else if (!en)
            active_duty <= shadow_duty;
        else if (commit)
            active_duty <= fade_next;
    end

    // Registered output with per-channel polarity.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_out <= INV;
        end else if (!en) begin
            pwm_out <= INV;
        end else begin
            case (mode)
                CH_OFF:  pwm_out <= INV;
                CH_ON:   pwm_out <= ~INV;
                default: pwm_out <= (counter < active_duty) ^ INV;
            endcase
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator with a shared period counter and
// period-aligned duty commits through a valid/ready write port.
// Optional feature: define PWM_FADE_EN to ramp active duty toward the
// written value by FADE_STEP per period instead of jumping in one step.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int                NUM_CH    = DEF_NUM_CH,
    parameter int                WIDTH     = DEF_WIDTH,
    parameter logic [NUM_CH-1:0] INVERT    = '0,
    parameter int                FADE_STEP = DEF_FADE_STEP,
    localparam int               CHW       = chw(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic [WIDTH-1:0]  period,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [CHW-1:0]    wr_ch,
    input  logic [WIDTH-1:0]  wr_duty,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_tick,
    output logic              err_ch
);

`ifdef PWM_FADE_EN
    localparam logic FADE_EN = 1'b1;
`else
    localparam logic FADE_EN = 1'b0;
`endif

    // A full-scale step makes the saturating fade land on the target in one
    // commit, so the non-fade build shares the same channel datapath.
    localparam logic [WIDTH-1:0] STEP = FADE_EN ? WIDTH'(FADE_STEP) : '1;

    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] period_q;
    logic             ready_q;
    logic             wr_fire;
    logic             wr_bad;

    assign period_tick = en && (counter == period_q);
    assign wr_ready    = ready_q && !period_tick;
    assign wr_fire     = wr_valid && wr_ready;
    assign wr_bad      = int'(wr_ch) >= NUM_CH;

    // Period counter; period input is only sampled at wrap or while disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter  <= '0;
            period_q <= '1;
        end else if (!en || (counter == period_q)) begin
            counter  <= '0;
            period_q <= period;
        end else begin
            counter  <= counter + WIDTH'(1);
        end
    end

    // Write-port readiness after reset and sticky bad-channel flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b0;
            err_ch  <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (wr_fire && wr_bad)
                err_ch <= 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pwm_channel #(
            .WIDTH (WIDTH),
            .INV   (INVERT[i]),
            .STEP  (STEP)
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .en       (en),
            .commit   (period_tick),
            .wr_en    (wr_fire && !wr_bad && (wr_ch == CHW'(i))),
            .wr_duty  (wr_duty),
            .counter  (counter),
            .period_q (period_q),
            .pwm_out  (pwm_out[i])
        );
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Scoreboard bench for pwm_multi: a driver issues directed and random
// stimulus, pushes the reference model's expected outputs per cycle, and a
// monitor pops and compares them against the DUT.
module tb_pwm_multi;

    localparam int         N     = 3;
    localparam int         W     = 8;
    localparam logic [2:0] INV   = 3'b001;
    localparam int         FSTEP = 2;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic [W-1:0] period = '0;
    logic         wr_valid = 1'b0;
    logic         wr_ready;
    logic [1:0]   wr_ch = '0;
    logic [W-1:0] wr_duty = '0;
    logic [N-1:0] pwm_out;
    logic         period_tick;
    logic         err_ch;

    always #5 clk = ~clk;

    pwm_multi #(
        .NUM_CH    (N),
        .WIDTH     (W),
        .INVERT    (INV),
        .FADE_STEP (FSTEP)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (en),
        .period      (period),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_ch       (wr_ch),
        .wr_duty     (wr_duty),
        .pwm_out     (pwm_out),
        .period_tick (period_tick),
        .err_ch      (err_ch)
    );

    typedef struct {
        logic [N-1:0] pwm;
        logic         tick;
        logic         rdy;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model state, expressed as plain numbers.
    int           m_cnt, m_per;
    int           m_sh[N];
    int           m_act[N];
    logic [N-1:0] m_out;
    bit           m_rdy, m_err;

`ifdef PWM_FADE_EN
    localparam bit FADE_ON = 1'b1;
`else
    localparam bit FADE_ON = 1'b0;
`endif

    function automatic int toward(input int cur, input int tgt);
        int step = FADE_ON ? FSTEP : 1 << 30;
        if (tgt > cur) return (tgt - cur <= step) ? tgt : cur + step;
        if (cur > tgt) return (cur - tgt <= step) ? tgt : cur - step;
        return cur;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_per = (1 << W) - 1;
        for (int i = 0; i < N; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        m_out = INV;
        m_rdy = 0;
        m_err = 0;
    endtask

    // One clock cycle: drive inputs, queue the expected outputs, advance the model.
    task automatic cycle(input bit rst_n, input bit e, input int p,
                         input bit v, input int ch, input int d);
        exp_t         x;
        bit           tick, rdy, fire;
        logic [N-1:0] nout;
        @(negedge clk);
        #1;
        reset_n  = rst_n;
        en       = e;
        period   = p[W-1:0];
        wr_valid = v;
        wr_ch    = ch[1:0];
        wr_duty  = d[W-1:0];
        if (!rst_n) model_reset();
        tick   = e && (m_cnt == m_per);
        rdy    = m_rdy && !tick;
        x.pwm  = m_out;
        x.tick = tick;
        x.rdy  = rdy;
        x.err  = m_err;
        exp_q.push_back(x);
        if (rst_n) begin
            fire = v && rdy;
            for (int i = 0; i < N; i++) begin
                nout[i] = e ? ((m_cnt < m_act[i]) ^ INV[i]) : INV[i];
                if (!e) m_act[i] = m_sh[i];
                else if (tick) m_act[i] = toward(m_act[i], m_sh[i]);
            end
            if (fire) begin
                if (ch < N) m_sh[ch] = d;
                else m_err = 1;
            end
            if (!e || tick) begin
                m_cnt = 0;
                m_per = p;
            end else begin
                m_cnt++;
            end
            m_out = nout;
            m_rdy = 1;
        end
    endtask

    task automatic idle(input int n, input bit e, input int p);
        for (int k = 0; k < n; k++) cycle(1, e, p, 0, 0, 0);
    endtask

    task automatic run_to_cnt(input int target, input int p);
        int k = 0;
        while (m_cnt != target && k < 300) begin
            cycle(1, 1, p, 0, 0, 0);
            k++;
        end
        check("reach_counter", m_cnt, target);
    endtask

    // Monitor: compare DUT outputs against the queued expectation each cycle.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            #3;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                check("pwm_out", pwm_out, x.pwm);
                check("period_tick", period_tick, x.tick);
                check("wr_ready", wr_ready, x.rdy);
                check("err_ch", err_ch, x.err);
            end
        end
    end

    initial begin
        int hi0, hi1, hi2, ticks;
        bit r_en;
        int r_per;
        model_reset();

        // Reset state, then release.
        for (int k = 0; k < 3; k++) cycle(0, 0, 9, 0, 0, 0);
        idle(2, 0, 9);

        // Disabled: period and duties load directly; then start running.
        cycle(1, 0, 9, 1, 0, 3);
        cycle(1, 0, 9, 1, 1, 3);
        cycle(1, 0, 9, 1, 2, 0);
        idle(2, 0, 9);
        idle(5, 1, 9);

        // Basic duty over two full periods.
        hi0 = 0; hi1 = 0; hi2 = 0; ticks = 0;
        for (int k = 0; k < 20; k++) begin
            cycle(1, 1, 9, 0, 0, 0);
            #2;
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
            hi2 += int'(pwm_out[2]);
            ticks += int'(period_tick);
        end
        check("count_ch0_inverted", hi0, 14);
        check("count_ch1", hi1, 6);
        check("count_ch2_zero", hi2, 0);
        check("count_ticks", ticks, 2);

        // Mid-period write commits only at the next tick.
        run_to_cnt(4, 9);
        cycle(1, 1, 9, 1, 1, 7);
        idle(25, 1, 9);

        // Boundaries: duty above period, duty zero, then period zero.
        run_to_cnt(2, 9);
        cycle(1, 1, 9, 1, 0, 10);
        cycle(1, 1, 9, 1, 2, 0);
        cycle(1, 1, 9, 1, 1, 1);
        idle(25, 1, 0);
        idle(10, 1, 0);

        // Out-of-range channel: discarded, sticky error.
        run_to_cnt(0, 9);
        idle(3, 1, 9);
        cycle(1, 1, 9, 1, 3, 99);
        idle(15, 1, 9);

        // Randomized operation.
        r_en = 1;
        r_per = 9;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 39) == 0) r_en = !r_en;
            if ($urandom_range(0, 29) == 0) r_per = $urandom_range(0, 12);
            if ($urandom_range(0, 3) == 0)
                cycle(1, r_en, r_per, 1, $urandom_range(0, 3), $urandom_range(0, 14));
            else
                cycle(1, r_en, r_per, 0, 0, 0);
        end

        // Reset in the middle of a period, then recovery.
        idle(2, 1, 9);
        run_to_cnt(4, 9);
        cycle(0, 1, 9, 0, 0, 0);
        cycle(0, 1, 9, 0, 0, 0);
        cycle(1, 1, 9, 0, 0, 0);
        idle(5, 1, 9);
        cycle(1, 1, 9, 1, 1, 5);
        idle(20, 1, 9);

        // More randomized operation after reset.
        r_en = 1;
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 49) == 0) r_en = !r_en;
            if ($urandom_range(0, 29) == 0) r_per = $urandom_range(0, 12);
            if ($urandom_range(0, 2) == 0)
                cycle(1, r_en, r_per, 1, $urandom_range(0, 3), $urandom_range(0, 14));
            else
                cycle(1, r_en, r_per, 0, 0, 0);
        end

        repeat (3) @(negedge clk);
        #5;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
